// File: rtl/bmem_line_arbiter_pkg.sv
// bmem_arb_pkg: shared types and geometry helpers for the bmem line arbiter
package bmem_arb_pkg;
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} state_t;
  typedef enum logic {RD, WR} op_t;
  function automatic int beats(input int line_bits, input int beat_bits);
    return line_bits / beat_bits;
  endfunction
  function automatic int offset_w(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction
endpackage

// File: rtl/bmem_line_arbiter_if.sv
// bmem_line_arbiter_if: client request/response and bmem burst port bundle
interface bmem_line_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
);
  logic [NUM_CLIENTS-1:0] cli_read, cli_write, cli_cancel, cli_resp;
  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr;
  logic [NUM_CLIENTS*LINE_BITS-1:0] cli_wdata;
  logic [LINE_BITS-1:0] cli_rdata;
  logic [ADDR_W-1:0] bmem_addr, bmem_raddr;
  logic [BEAT_BITS-1:0] bmem_wdata, bmem_rdata;
  logic bmem_read, bmem_write, bmem_ready, bmem_rvalid, spurious_beat;
  modport master(
    output cli_read, cli_write, cli_cancel, cli_addr, cli_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input cli_rdata, cli_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata, spurious_beat
  );
  modport slave(
    input cli_read, cli_write, cli_cancel, cli_addr, cli_wdata,
    input bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output cli_rdata, cli_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata, spurious_beat
  );
endinterface

// File: rtl/bmem_line_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant, search starts at ptr
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);
  logic found;
  int j;
  always_comb begin
    grant = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bmem_line_arbiter.sv
// bmem_line_arbiter: serialises whole-line refills/write-backs from N clients onto one bmem port
module bmem_line_arbiter
  import bmem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input logic clk,
  input logic rst,
  bmem_line_arbiter_if.slave bus
);
  localparam int BEATS = beats(LINE_BITS, BEAT_BITS);
  localparam int OFFSET_W = offset_w(LINE_BITS);
  localparam int CW = $clog2(BEATS);
  localparam int OW = $clog2(NUM_CLIENTS);
  localparam logic [ADDR_W-1:0] LO = ADDR_W'((1 << OFFSET_W) - 1);
  state_t state;
  op_t nop;
  logic [OW-1:0] owner, ptr, gidx;
  logic [CW-1:0] cnt;
  logic drop, hit, last, own_cancel;
  logic [ADDR_W-1:0] addr, gaddr;
  logic [LINE_BITS-1:0] wline, line;
  logic [NUM_CLIENTS-1:0] req, grant;
  assign req = bus.cli_read | bus.cli_write;
  rr_arbiter #(.N(NUM_CLIENTS)) u_rr (.req(req), .ptr(ptr), .grant(grant));
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) if (grant[i]) gidx = OW'(i);
  end
  assign gaddr = bus.cli_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign nop = bus.cli_write[gidx] ? WR : RD;
  // beats are matched on line bits only; byte offset of the tag is ignored
  assign hit = bus.bmem_rvalid && state == RD_DATA && ((bus.bmem_raddr ^ addr) & ~LO) == '0;
  assign last = cnt == CW'(BEATS - 1);
  assign own_cancel = bus.cli_cancel[owner];
  assign bus.bmem_read = state == RD_CMD;
  assign bus.bmem_write = state == WR_DATA;
  assign bus.bmem_addr = (state == RD_CMD || state == WR_DATA) ? addr : '0;
  assign bus.bmem_wdata = state == WR_DATA ? wline[int'(cnt)*BEAT_BITS +: BEAT_BITS] : '0;
  assign bus.cli_resp = state == RESP ? NUM_CLIENTS'(1) << owner : '0;
  assign bus.cli_rdata = line;
  assign bus.spurious_beat = bus.bmem_rvalid && !hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      cnt <= '0;
      drop <= 1'b0;
      addr <= '0;
      wline <= '0;
      line <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          owner <= gidx;
          addr <= gaddr & ~LO;
          wline <= bus.cli_wdata[int'(gidx)*LINE_BITS +: LINE_BITS];
          cnt <= '0;
          drop <= 1'b0;
          state <= nop == WR ? WR_DATA : RD_CMD;
        end
        RD_CMD: state <= own_cancel ? IDLE : bus.bmem_ready ? RD_DATA : RD_CMD;
        RD_DATA: begin
          if (own_cancel) drop <= 1'b1;
          if (hit) begin
            line[int'(cnt)*BEAT_BITS +: BEAT_BITS] <= bus.bmem_rdata;
            cnt <= cnt + CW'(1);
            if (last) state <= (drop || own_cancel) ? IDLE : RESP;
          end
        end
        WR_DATA: if (bus.bmem_ready) begin
          cnt <= cnt + CW'(1);
          if (last) state <= RESP;
        end
        RESP: begin
          ptr <= owner == OW'(NUM_CLIENTS - 1) ? '0 : owner + OW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bmem_line_arbiter.sv
// tb_bmem_line_arbiter: directed stimulus with a cycle-stamped scoreboard of bmem/client events
module tb_bmem_line_arbiter;
  localparam int K_CMD = 0, K_WR = 1, K_SPUR = 2, K_RESP = 3;
  typedef struct {
    int kind;
    int cyc;
    logic [31:0] a;
    logic [255:0] d;
    bit nod;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, passes = 0, ncyc = 0;
  ev_t q[$];
  bmem_line_arbiter_if #(.NUM_CLIENTS(2), .ADDR_W(32), .LINE_BITS(256), .BEAT_BITS(64)) bus ();
  bmem_line_arbiter #(.NUM_CLIENTS(2), .ADDR_W(32), .LINE_BITS(256), .BEAT_BITS(64)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;
  task automatic push(input int k, input int cy, input logic [31:0] a, input logic [255:0] d, input bit nod);
    ev_t e;
    e.kind = k;
    e.cyc = cy;
    e.a = a;
    e.d = d;
    e.nod = nod;
    q.push_back(e);
  endtask
  task automatic chk(input int k, input logic [31:0] a, input logic [255:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      $display("FAIL unexpected event kind=%0d cyc=%0d a=%h", k, ncyc, a);
      return;
    end
    e = q.pop_front();
    if (e.kind == k && e.cyc == ncyc && e.a == a && (e.nod || e.d == d)) passes++;
    else $display("FAIL event: got kind=%0d cyc=%0d a=%h d=%h, want kind=%0d cyc=%0d a=%h d=%h",
                  k, ncyc, a, d, e.kind, e.cyc, e.a, e.d);
  endtask
  task automatic zchk(input string n, input logic [255:0] v);
    checks++;
    if (v == '0) passes++;
    else $display("FAIL %s after reset: got %h, want 0", n, v);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bmem_read && bus.bmem_ready) chk(K_CMD, bus.bmem_addr, '0);
      if (bus.bmem_write && bus.bmem_ready) chk(K_WR, bus.bmem_addr, 256'(bus.bmem_wdata));
      if (bus.spurious_beat) chk(K_SPUR, '0, '0);
      if (|bus.cli_resp) chk(K_RESP, 32'(bus.cli_resp), bus.cli_rdata);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic nobeat();
    cyc();
    bus.bmem_rvalid = 1'b0;
  endtask
  task automatic beat(input logic [31:0] a, input logic [63:0] d);
    cyc();
    bus.bmem_rvalid = 1'b1;
    bus.bmem_raddr = a;
    bus.bmem_rdata = d;
  endtask
  task automatic set_rd(input int c, input logic [31:0] a);
    bus.cli_addr[c*32 +: 32] = a;
    bus.cli_read[c] = 1'b1;
  endtask
  function automatic logic [255:0] mk(input logic [15:0] s);
    logic [255:0] l;
    for (int i = 0; i < 4; i++) l[i*64 +: 64] = {s, 16'(i), 32'hC0DE_0000 + 32'(i)};
    return l;
  endfunction
  // caller has already raised the request in the current (IDLE) cycle
  task automatic rd_txn(input int c, input logic [31:0] a, input logic [255:0] l);
    int t;
    t = ncyc;
    push(K_CMD, t + 1, a, '0, 1'b0);
    push(K_RESP, t + 6, 32'(1 << c), l, 1'b0);
    nobeat();
    for (int i = 0; i < 4; i++) beat(a, l[i*64 +: 64]);
    nobeat();
    bus.cli_read[c] = 1'b0;
  endtask
  initial begin
    int t;
    int rs[6] = '{1, 0, 1, 1, 0, 1};
    logic [255:0] w;
    bus.cli_read = '0;
    bus.cli_write = '0;
    bus.cli_cancel = '0;
    bus.cli_addr = '0;
    bus.cli_wdata = '0;
    bus.bmem_ready = 1'b1;
    bus.bmem_raddr = '0;
    bus.bmem_rdata = '0;
    bus.bmem_rvalid = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    zchk("bmem_read", 256'(bus.bmem_read));
    zchk("cli_resp", 256'(bus.cli_resp));
    zchk("bmem_addr", 256'(bus.bmem_addr));
    set_rd(0, 32'h0000_1040);
    rd_txn(0, 32'h0000_1040, {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA});
    nobeat();
    w = {64'h4444_4444_0000_0004, 64'h3333_3333_0000_0003, 64'h2222_2222_0000_0002, 64'h1111_1111_0000_0001};
    bus.cli_addr[63:32] = 32'h8000_0020;
    bus.cli_wdata[511:256] = w;
    bus.cli_write[1] = 1'b1;
    t = ncyc;
    push(K_WR, t + 1, 32'h8000_0020, 256'(w[63:0]), 1'b0);
    push(K_WR, t + 3, 32'h8000_0020, 256'(w[127:64]), 1'b0);
    push(K_WR, t + 4, 32'h8000_0020, 256'(w[191:128]), 1'b0);
    push(K_WR, t + 6, 32'h8000_0020, 256'(w[255:192]), 1'b0);
    push(K_RESP, t + 7, 32'h2, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      bus.bmem_ready = rs[i][0];
    end
    cyc();
    bus.bmem_ready = 1'b1;
    bus.cli_write[1] = 1'b0;
    nobeat();
    set_rd(0, 32'h0000_1000);
    set_rd(1, 32'h0000_2000);
    rd_txn(0, 32'h0000_1000, mk(16'h0C01));
    nobeat();
    set_rd(0, 32'h0000_3000);
    rd_txn(1, 32'h0000_2000, mk(16'h0C02));
    nobeat();
    set_rd(1, 32'h0000_4000);
    rd_txn(0, 32'h0000_3000, mk(16'h0C03));
    nobeat();
    rd_txn(1, 32'h0000_4000, mk(16'h0C04));
    nobeat();
    set_rd(0, 32'h0000_5000);
    set_rd(1, 32'h0000_6000);
    t = ncyc;
    push(K_CMD, t + 1, 32'h0000_5000, '0, 1'b0);
    nobeat();
    beat(32'h0000_5000, 64'h50);
    beat(32'h0000_5000, 64'h51);
    bus.cli_cancel[0] = 1'b1;
    bus.cli_read[0] = 1'b0;
    beat(32'h0000_5000, 64'h52);
    bus.cli_cancel[0] = 1'b0;
    beat(32'h0000_5000, 64'h53);
    nobeat();
    rd_txn(1, 32'h0000_6000, mk(16'h0D06));
    nobeat();
    w = mk(16'h0E01);
    set_rd(0, 32'h0000_1000);
    bus.bmem_rvalid = 1'b1;
    bus.bmem_raddr = 32'h0000_1000;
    bus.bmem_rdata = 64'hDEAD;
    t = ncyc;
    push(K_SPUR, t, '0, '0, 1'b0);
    push(K_CMD, t + 1, 32'h0000_1000, '0, 1'b0);
    push(K_SPUR, t + 3, '0, '0, 1'b0);
    push(K_RESP, t + 7, 32'h1, w, 1'b0);
    nobeat();
    beat(32'h0000_1000, w[63:0]);
    beat(32'h0000_2000, 64'hBAD0_BAD0_BAD0_BAD0);
    beat(32'h0000_1000, w[127:64]);
    beat(32'h0000_1000, w[191:128]);
    beat(32'h0000_1000, w[255:192]);
    nobeat();
    bus.cli_read[0] = 1'b0;
    nobeat();
    w = mk(16'h0F01);
    bus.cli_addr[63:32] = 32'h0000_9000;
    bus.cli_wdata[511:256] = w;
    bus.cli_write[1] = 1'b1;
    t = ncyc;
    push(K_WR, t + 1, 32'h0000_9000, 256'(w[63:0]), 1'b0);
    push(K_WR, t + 2, 32'h0000_9000, 256'(w[127:64]), 1'b0);
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    bus.cli_write[1] = 1'b0;
    cyc();
    rst = 1'b0;
    zchk("bmem_read", 256'(bus.bmem_read));
    zchk("bmem_write", 256'(bus.bmem_write));
    zchk("bmem_addr", 256'(bus.bmem_addr));
    zchk("bmem_wdata", 256'(bus.bmem_wdata));
    zchk("cli_resp", 256'(bus.cli_resp));
    zchk("cli_rdata", bus.cli_rdata);
    zchk("spurious_beat", 256'(bus.spurious_beat));
    set_rd(0, 32'h0000_A000);
    set_rd(1, 32'h0000_B000);
    rd_txn(0, 32'h0000_A000, mk(16'h0A0A));
    nobeat();
    rd_txn(1, 32'h0000_B000, mk(16'h0B0B));
    repeat (3) nobeat();
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL pending events: got %0d outstanding, want 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
